// File: rtl/spi_client_arbiter.sv
// spi_client_arbiter: shares one SPI master core between several clients.
// Round-robin grant, chip-select routing, response return and a watchdog.
module spi_client_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DATA_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CLIENTS-1:0]             req_valid,
    input  logic [NUM_CLIENTS*DATA_LENGTH-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]             req_ready,
    output logic [NUM_CLIENTS-1:0]             rsp_valid,
    output logic [DATA_LENGTH-1:0]             rsp_data,
    output logic                               rsp_err,
    output logic                               m_start,
    output logic [DATA_LENGTH-1:0]             m_data_in,
    input  logic                               m_busy,
    input  logic                               m_done,
    input  logic [DATA_LENGTH-1:0]             m_data_out,
    input  logic                               m_cs_n,
    output logic [NUM_CLIENTS-1:0]             slv_cs_n
);

    localparam int PTR_W = $clog2(NUM_CLIENTS);
    localparam int SW    = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [PTR_W-1:0] LAST_CLIENT = PTR_W'(NUM_CLIENTS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_ACTIVE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;

    logic [2:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    logic [SW-1:0]    scan;
    logic [TMR_W-1:0] timer;

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    // Scanning downward lets the nearest candidate win the last assignment.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NUM_CLIENTS)) begin
                scan = scan - SW'(NUM_CLIENTS);
            end
            if (req_valid[scan[PTR_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[PTR_W-1:0];
            end
        end
    end

    // Accept pulse goes to the winner only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == S_IDLE && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Response pulse and core start are decoded straight from the state.
    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP) begin
            rsp_valid[owner] = 1'b1;
        end
        m_start = (state == S_ISSUE);
    end

    // Route the core chip select to the owner; idle keeps every slave off.
    always_comb begin
        slv_cs_n = '1;
        if (state != S_IDLE) begin
            slv_cs_n[owner] = m_cs_n;
        end
    end

    // Transfer sequencer: grant, start, watch, capture, respond, drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            timer     <= '0;
            m_data_in <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        owner     <= gnt_idx;
                        m_data_in <= req_data[gnt_idx*DATA_LENGTH +: DATA_LENGTH];
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    timer <= timer + 1'b1;
                    if (m_done && !m_busy) begin
                        state <= S_CAPTURE;
                    end else if (timer == TMR_LAST) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                        state    <= S_RESP;
                    end
                end
                S_CAPTURE: begin
                    rsp_data <= m_data_out;
                    rsp_err  <= 1'b0;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    rr_ptr  <= (owner == LAST_CLIENT) ? '0 : owner + 1'b1;
                    rsp_err <= 1'b0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (!m_done && !m_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_client_arbiter.md
Name: spi_client_arbiter

Overview:
- Shares one SPI master core between NUM_CLIENTS requesters, each with its own SPI slave.
- Arbitrates requests round-robin and launches one transfer on the core at a time.
- Routes the core's single chip-select to the owning client's slave, and returns the received word with a per-client response pulse.
- Adds a watchdog that aborts and flags a transfer if the core never completes.

Parameters:
- NUM_CLIENTS, 4, number of requesters/slaves (2..8).
- DATA_LENGTH, 8, SPI word width; must match the core.
- TIMEOUT_CYCLES, 1024, max clk cycles from start to core done before abort (>=16).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_CLIENTS  per-client transfer request, held until accepted.
- req_data  in  NUM_CLIENTS*DATA_LENGTH  per-client TX word; client i occupies bits [i*DATA_LENGTH +: DATA_LENGTH].
- req_ready  out  NUM_CLIENTS  one-hot accept pulse; the request is consumed on req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_CLIENTS  one-hot single-cycle response pulse to the owning client.
- rsp_data  out  DATA_LENGTH  RX word; valid while any rsp_valid bit is high.
- rsp_err  out  1  high with rsp_valid when the transfer timed out.
- m_start  out  1  start pulse to the SPI core.
- m_data_in  out  DATA_LENGTH  TX word to the core, held stable from start until done.
- m_busy  in  1  core busy.
- m_done  in  1  core completion; treated as a level and acted on only in ACTIVE.
- m_data_out  in  DATA_LENGTH  core RX word; valid the cycle after m_done is first seen high.
- m_cs_n  in  1  core chip select (active-low).
- slv_cs_n  out  NUM_CLIENTS  per-slave chip select; slv_cs_n[owner] = m_cs_n, all others 1.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - m_start=0, m_data_in=0, slv_cs_n=all 1s.
  - rr_ptr=0, owner=0, timer=0, state=IDLE.
- States:
  - IDLE: if any req_valid, pick the first set bit at or after rr_ptr, scanning upward and wrapping. Register owner and m_data_in=req_data[owner]. Pulse req_ready[owner] for 1 cycle. Go to ISSUE.
  - ISSUE: m_start=1 for exactly 1 cycle; timer cleared. Go to ACTIVE.
  - ACTIVE:
    - timer increments each cycle.
    - On m_done=1 with m_busy=0, go to CAPTURE.
    - Else if timer==TIMEOUT_CYCLES-1, go to RESP with rsp_err=1 and rsp_data=0.
  - CAPTURE: wait 1 cycle, latch m_data_out into rsp_data with rsp_err=0. Go to RESP.
  - RESP: rsp_valid[owner]=1 for 1 cycle. rr_ptr = owner+1, wrapping to 0 after NUM_CLIENTS-1. Go to GAP.
  - GAP: wait until m_done=0 and m_busy=0, then go to IDLE. This prevents a level-held done from re-triggering.
- Latency and throughput:
  - Accept to m_start is 1 cycle.
  - Core done to rsp_valid is 2 cycles.
  - At most one transfer is outstanding.
- Request handling:
  - req_valid may drop without being accepted; it is simply no longer considered.
  - req_data is sampled only in the accept cycle.
- slv_cs_n: combinational from m_cs_n and the registered owner. Owner stays stable from IDLE-accept through GAP, so there are no CS glitches on non-owners.
- Simultaneous requests resolve strictly by round-robin. A client that was just served has the lowest priority in the next arbitration.
- Timeout: the arbiter does not reset the core. The GAP state still waits for the core to go idle before the next grant.
- Reset mid-transfer: all outputs return to reset values immediately (async). No response is issued for the aborted transfer.
- Out-of-range width rule: bits of req_data beyond NUM_CLIENTS*DATA_LENGTH do not exist. rr_ptr width is $clog2(NUM_CLIENTS), with explicit wrap at NUM_CLIENTS-1 for non-power-of-2 counts.

Test Plan:
- Single request: client 2 req_data=0xA5, core model returns 0x3C → req_ready[2] pulses once, m_start one cycle later, rsp_valid=4'b0100, rsp_data=0x3C, rsp_err=0, slv_cs_n=4'b1011 only while m_cs_n=0.
- Contention: all 4 clients valid continuously from reset → grant order 0,1,2,3,0 with exactly one m_start per grant and no overlap of core activity.
- Fairness after skip: rr_ptr=1, only clients 0 and 3 valid → client 3 granted first, then client 0.
- Timeout: TIMEOUT_CYCLES=32, core never asserts m_done → rsp_valid[owner] with rsp_err=1 and rsp_data=0 exactly 32 cycles after ACTIVE entry.
- Level done: core holds m_done=1 for 20 cycles after completion, client 1 valid again → no new grant until m_done=0, and exactly one response per transfer.
- Async reset asserted during ACTIVE → all outputs at reset values in the same cycle, and no rsp_valid after release until a new request completes.
